// File: rtl/uart_rx_axis_fifo.sv
// rtl/uart_rx_axis_fifo.sv - UART receiver with mid-bit sampling, error flags and FWFT AXI-Stream FIFO.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_axis_fifo #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1,
  parameter int FIFO_DEPTH    = 16,
  localparam int TDATA_W      = ((BIT_PER_WORD + 7) / 8) * 8,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               RX,
  output logic [TDATA_W-1:0] tdata,
  output logic [2:0]         tuser,
  output logic               tvalid,
  input  logic               tready,
  input  logic               ovf_clr,
  output logic               overflow,
  output logic [CNT_W-1:0]   fifo_count
);

  localparam int CPP  = (CLK_FREQ * 1000000) / BIT_RATE;
  localparam int HALF = CPP / 2;
  localparam int CW   = $clog2(CPP + 1);
  localparam int BCW  = $clog2(BIT_PER_WORD + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WW   = BIT_PER_WORD + 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t                  state;
  logic                    rx_meta, rxs, rxs_prev;
  logic [CW-1:0]           cnt, cmax;
  logic [BCW-1:0]          bit_cnt;
  logic [BIT_PER_WORD-1:0] shreg;
  logic                    par_bit, par_err, frame_err;
  logic                    at_max, sample, bit_val;
  logic                    last_stop, fe_now, brk, push_en, pop, full, do_push, ovf_set;
  logic [WW-1:0]           push_word, rd_word;
  logic [WW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= RX;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign cmax   = (state == START) ? CW'(HALF - 1) : CW'(CPP - 1);
  assign at_max = (state != IDLE) && (cnt == cmax);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision lands one cycle after the centre so the MAX+1 sample is available.
  logic [1:0] rxs_hist;
  logic       samp_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rxs_hist <= 2'b11;
      samp_q   <= 1'b0;
    end else begin
      rxs_hist <= {rxs_hist[0], rxs};
      samp_q   <= at_max;
    end
  end
  assign sample  = samp_q;
  assign bit_val = (rxs & rxs_hist[0]) | (rxs & rxs_hist[1]) | (rxs_hist[0] & rxs_hist[1]);
`else
  assign sample  = at_max;
  assign bit_val = rxs;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (state == IDLE || at_max) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          // Edge-triggered so a line stuck low after a break cannot re-arm.
          if (rxs_prev && !rxs) begin
            state     <= START;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
          end
        end
        START: if (sample) state <= bit_val ? IDLE : DATA;
        DATA: begin
          if (sample) begin
            shreg   <= {bit_val, shreg[BIT_PER_WORD-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BCW'(BIT_PER_WORD - 1))
              state <= (PARITY_BIT != 0) ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (sample) begin
            par_bit <= bit_val;
            par_err <= (PARITY_BIT == 1) ? ~^{shreg, bit_val} : ^{shreg, bit_val};
            state   <= STOP1;
          end
        end
        STOP1: begin
          if (sample) begin
            frame_err <= frame_err | ~bit_val;
            state     <= (STOP_BITS_NUM == 2) ? STOP2 : IDLE;
          end
        end
        STOP2: if (sample) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign last_stop = sample && ((state == STOP1 && STOP_BITS_NUM != 2) || state == STOP2);
  assign fe_now    = frame_err | ~bit_val;
  assign brk       = (shreg == '0) && !par_bit && fe_now;
  assign push_word = {brk, fe_now, par_err, shreg};
  assign push_en   = last_stop;

  assign tvalid  = (count != '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = tvalid && tready;
  assign do_push = push_en && (!full || pop);
  assign ovf_set = push_en && full && !pop;

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign rd_word    = mem[rd_ptr];
  assign tdata      = tvalid ? TDATA_W'(rd_word[BIT_PER_WORD-1:0]) : '0;
  assign tuser      = tvalid ? rd_word[WW-1:BIT_PER_WORD] : 3'b000;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// tb/tb_uart_rx_axis_fifo.sv - self-checking bench: 8N1 (depth 4) and 8E2 (depth 4) receivers.
module tb_uart_rx_axis_fifo;

  localparam int CPP  = 16;
  localparam int HALF = 8;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       rx_n = 1'b1, rx_e = 1'b1;
  logic       tready_n = 1'b0, tready_e = 1'b0;
  logic       ovf_clr_n = 1'b0, ovf_clr_e = 1'b0;
  logic [7:0] tdata_n, tdata_e;
  logic [2:0] tuser_n, tuser_e;
  logic       tvalid_n, tvalid_e, overflow_n, overflow_e;
  logic [2:0] fifo_count_n, fifo_count_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0_n     = 0;
  int rise_n   = 0;
  logic tv_n_prev = 1'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (tvalid_n && !tv_n_prev) rise_n = cyc;
    tv_n_prev = tvalid_n;
  end

  uart_rx_axis_fifo #(.CLK_FREQ(100), .BIT_RATE(6250000), .BIT_PER_WORD(8), .PARITY_BIT(0),
                      .STOP_BITS_NUM(1), .FIFO_DEPTH(4)) dut_n (
    .aclk(aclk), .aresetn(aresetn), .RX(rx_n), .tdata(tdata_n), .tuser(tuser_n),
    .tvalid(tvalid_n), .tready(tready_n), .ovf_clr(ovf_clr_n), .overflow(overflow_n),
    .fifo_count(fifo_count_n));

  uart_rx_axis_fifo #(.CLK_FREQ(100), .BIT_RATE(6250000), .BIT_PER_WORD(8), .PARITY_BIT(2),
                      .STOP_BITS_NUM(2), .FIFO_DEPTH(4)) dut_e (
    .aclk(aclk), .aresetn(aresetn), .RX(rx_e), .tdata(tdata_e), .tuser(tuser_e),
    .tvalid(tvalid_e), .tready(tready_e), .ovf_clr(ovf_clr_e), .overflow(overflow_e),
    .fifo_count(fifo_count_e));

  // Expected {break, frame_err, parity_err, data} from the frame contents.
  function automatic logic [10:0] model(input int par_mode, input logic [7:0] d, input logic p,
                                        input logic s1, input logic s2, input int nstop);
    logic fe, pe, bk;
    int   ones;
    ones = $countones(d) + ((par_mode != 0 && p) ? 1 : 0);
    fe   = !s1 || (nstop == 2 && !s2);
    pe   = (par_mode == 0) ? 1'b0 : (par_mode == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    bk   = (d == 8'h00) && (par_mode == 0 || !p) && fe;
    return {bk, fe, pe, d};
  endfunction

  task automatic set_line(input int which, input logic b);
    if (which == 0) rx_n = b;
    else            rx_e = b;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic p,
                            input logic s1, input logic s2);
    logic [15:0] bits;
    int nb;
    if (which == 0) begin bits = {5'b0, s1, d, 1'b0}; nb = 10; end
    else            begin bits = {3'b0, s2, s1, p, d, 1'b0}; nb = 12; end
    @(posedge aclk); #1;
    if (which == 0) t0_n = cyc;
    for (int i = 0; i < nb; i++) begin
      set_line(which, bits[i]);
      repeat (CPP) @(posedge aclk);
      #1;
    end
    set_line(which, 1'b1);
  endtask

  task automatic wait_valid(input int which, input int max_cyc, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < max_cyc) begin
      @(negedge aclk);
      ok = (which == 0) ? tvalid_n : tvalid_e;
      i++;
    end
  endtask

  task automatic pop(input int which);
    @(negedge aclk);
    if (which == 0) tready_n = 1'b1; else tready_e = 1'b1;
    @(negedge aclk);
    if (which == 0) tready_n = 1'b0; else tready_e = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({tvalid_n, tdata_n, tuser_n, overflow_n, fifo_count_n} !== '0) begin
      n_fail++; $display("FAIL reset_n: got %b required all zero", {tvalid_n, tdata_n, tuser_n, overflow_n, fifo_count_n});
    end
    n_checks++;
    if ({tvalid_e, tdata_e, tuser_e, overflow_e, fifo_count_e} !== '0) begin
      n_fail++; $display("FAIL reset_e: got %b required all zero", {tvalid_e, tdata_e, tuser_e, overflow_e, fifo_count_e});
    end
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
  endtask

  task automatic test_8n1;
    bit ok;
    int d;
    logic [10:0] exp;
    exp = model(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 4 * CPP, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL 8n1_timeout: tvalid never rose"); end
    n_checks++;
    if ({tuser_n, tdata_n} !== exp) begin
      n_fail++; $display("FAIL 8n1_word: got %h required %h", {tuser_n, tdata_n}, exp);
    end
    d = rise_n - t0_n;
    n_checks++;
    if (d < 9 * CPP + HALF || d > 9 * CPP + HALF + 6) begin
      n_fail++; $display("FAIL 8n1_latency: got %0d cycles required %0d..%0d", d, 9 * CPP + HALF, 9 * CPP + HALF + 6);
    end
    pop(0);
    n_checks++;
    if (tvalid_n !== 1'b0) begin n_fail++; $display("FAIL 8n1_one_beat: tvalid got %b required 0", tvalid_n); end
  endtask

  task automatic test_parity;
    bit ok;
    logic [10:0] exp;
    for (int p = 1; p >= 0; p--) begin
      exp = model(2, 8'h03, p[0], 1'b1, 1'b1, 2);
      send_frame(1, 8'h03, p[0], 1'b1, 1'b1);
      wait_valid(1, 4 * CPP, ok);
      n_checks++;
      if (!ok || {tuser_e, tdata_e} !== exp) begin
        n_fail++; $display("FAIL parity_p%0d: got %h valid %b required %h", p, {tuser_e, tdata_e}, ok, exp);
      end
      pop(1);
    end
  endtask

  task automatic test_break;
    bit ok;
    logic [10:0] exp;
    exp = model(0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
    @(posedge aclk); #1 rx_n = 1'b0;
    repeat (12 * CPP) @(posedge aclk);
    #1 rx_n = 1'b1;
    wait_valid(0, 2, ok);
    n_checks++;
    if (!ok || {tuser_n, tdata_n} !== exp) begin
      n_fail++; $display("FAIL break_word: got %h valid %b required %h", {tuser_n, tdata_n}, ok, exp);
    end
    repeat (4 * CPP) @(negedge aclk);
    n_checks++;
    if (fifo_count_n !== 3'd1) begin n_fail++; $display("FAIL break_single: count got %0d required 1", fifo_count_n); end
    pop(0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 4 * CPP, ok);
    n_checks++;
    if (!ok || {tuser_n, tdata_n} !== model(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1)) begin
      n_fail++; $display("FAIL break_rearm: got %h valid %b required 05a", {tuser_n, tdata_n}, ok);
    end
    pop(0);
  endtask

  task automatic test_glitch;
    bit ok;
    @(posedge aclk); #1 rx_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1 rx_n = 1'b1;
    repeat (3 * CPP) @(negedge aclk);
    n_checks++;
    if (tvalid_n !== 1'b0 || fifo_count_n !== 3'd0) begin
      n_fail++; $display("FAIL glitch_reject: tvalid %b count %0d required 0 0", tvalid_n, fifo_count_n);
    end
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 4 * CPP, ok);
    n_checks++;
    if (!ok || tdata_n !== 8'hC3) begin n_fail++; $display("FAIL glitch_recover: got %h required c3", tdata_n); end
    pop(0);
  endtask

  task automatic test_random;
    bit ok;
    logic [7:0] d;
    logic p, s1, s2;
    logic [10:0] exp;
    for (int k = 0; k < 10; k++) begin
      d  = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      if (k == 0) begin d = 8'h00; p = 1'b0; s1 = 1'b0; end
      exp = model(2, d, p, s1, s2, 2);
      send_frame(1, d, p, s1, s2);
      repeat (CPP) @(posedge aclk);
      wait_valid(1, 2 * CPP, ok);
      n_checks++;
      if (!ok || {tuser_e, tdata_e} !== exp) begin
        n_fail++; $display("FAIL random_%0d: got %h valid %b required %h", k, {tuser_e, tdata_e}, ok, exp);
      end
      pop(1);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    for (int k = 0; k < 5; k++) begin
      send_frame(0, 8'h11 + 8'(k), 1'b0, 1'b1, 1'b1);
      if (q.size() < 4) q.push_back(8'h11 + 8'(k));
    end
    repeat (2 * CPP) @(negedge aclk);
    n_checks++;
    if (fifo_count_n !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d required 4", fifo_count_n); end
    n_checks++;
    if (overflow_n !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow_n); end
    n_checks++;
    if (tdata_n !== 8'h11) begin n_fail++; $display("FAIL ovf_hold: got %h required 11", tdata_n); end
    while (q.size() > 0) begin
      n_checks++;
      if (!tvalid_n || tdata_n !== q[0]) begin
        n_fail++; $display("FAIL drain_order: got %h valid %b required %h", tdata_n, tvalid_n, q[0]);
      end
      void'(q.pop_front());
      pop(0);
    end
    n_checks++;
    if (tvalid_n !== 1'b0) begin n_fail++; $display("FAIL drain_empty: tvalid got %b required 0", tvalid_n); end
    @(negedge aclk) ovf_clr_n = 1'b1;
    @(negedge aclk) ovf_clr_n = 1'b0;
    n_checks++;
    if (overflow_n !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", overflow_n); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    send_frame(0, 8'h77, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 4 * CPP, ok);
    fork
      send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
      begin
        repeat (4 * CPP) @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        n_checks++;
        if ({tvalid_n, tdata_n, tuser_n, overflow_n, fifo_count_n} !== '0) begin
          n_fail++; $display("FAIL reset_mid: got %b required all zero", {tvalid_n, tdata_n, tuser_n, overflow_n, fifo_count_n});
        end
      end
    join
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2 * CPP) @(negedge aclk);
    n_checks++;
    if (fifo_count_n !== 3'd0) begin n_fail++; $display("FAIL reset_no_partial: count got %0d required 0", fifo_count_n); end
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    wait_valid(0, 4 * CPP, ok);
    n_checks++;
    if (!ok || {tuser_n, tdata_n} !== model(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1)) begin
      n_fail++; $display("FAIL reset_next_frame: got %h valid %b required 03c", {tuser_n, tdata_n}, ok);
    end
    pop(0);
  endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
  task automatic test_vote;
    bit ok;
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    @(posedge aclk); #1;
    for (int i = 0; i < 10; i++) begin
      rx_n = bits[i];
      if (i == 4) begin
        repeat (9) @(posedge aclk);
        #1 rx_n = ~bits[i];
        @(posedge aclk);
        #1 rx_n = bits[i];
        repeat (CPP - 10) @(posedge aclk);
      end else begin
        repeat (CPP) @(posedge aclk);
      end
      #1;
    end
    rx_n = 1'b1;
    wait_valid(0, 4 * CPP, ok);
    n_checks++;
    if (!ok || tdata_n !== 8'h55) begin n_fail++; $display("FAIL vote_glitch: got %h required 55", tdata_n); end
    pop(0);
  endtask
`endif

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_break;
    test_glitch;
    test_random;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_MAJORITY_VOTE_EN
    test_vote;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
